mtl_video_timing_gen: RTL and testbench

//  Parametrised successor to the fixed 800x480 clocked-video output that drives the MTL panel and VGA.

---
 rtl/mtl_video_pkg.sv | 56 +++++
 rtl/video_hv_counter.sv | 67 ++++++
 rtl/mtl_video_timing_gen.sv | 178 +++++++++++++++++
 tb/tb_mtl_video_timing_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mtl_video_pkg.sv
// Shared types, default MTL 800x480 timing and region decode for the clocked-video generator.
package mtl_video_pkg;

  typedef enum logic [0:0] {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FP     = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BP     = 2'd3
  } region_e;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } axis_timing_t;

  localparam int unsigned MTL_COLOR_W = 8;

  localparam axis_timing_t MTL_H_TIMING = '{
    active: 16'd800, fp: 16'd210, sync: 16'd30, bp: 16'd16
  };

  localparam axis_timing_t MTL_V_TIMING = '{
    active: 16'd480, fp: 16'd22, sync: 16'd3, bp: 16'd20
  };

  // Total period of one axis in clocks (horizontal) or lines (vertical).
  function automatic int unsigned axis_total(input axis_timing_t t);
    return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
  endfunction

  // Classify a counter value into active / front porch / sync / back porch.
  function automatic region_e axis_region(input int unsigned cnt,
                                          input int unsigned active,
                                          input int unsigned fp,
                                          input int unsigned sync);
    region_e r;
    if (cnt < active) begin
      r = REG_ACTIVE;
    end else if (cnt < active + fp) begin
      r = REG_FP;
    end else if (cnt < active + fp + sync) begin
      r = REG_SYNC;
    end else begin
      r = REG_BP;
    end
    return r;
  endfunction

endpackage

// File: rtl/video_hv_counter.sv
// Raster position counters with combinational region decode and frame-start strobe.
module video_hv_counter
  import mtl_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'(MTL_H_TIMING.active),
  parameter int unsigned H_FP     = 32'(MTL_H_TIMING.fp),
  parameter int unsigned H_SYNC   = 32'(MTL_H_TIMING.sync),
  parameter int unsigned H_BP     = 32'(MTL_H_TIMING.bp),
  parameter int unsigned V_ACTIVE = 32'(MTL_V_TIMING.active),
  parameter int unsigned V_FP     = 32'(MTL_V_TIMING.fp),
  parameter int unsigned V_SYNC   = 32'(MTL_V_TIMING.sync),
  parameter int unsigned V_BP     = 32'(MTL_V_TIMING.bp)
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_de_c,
  output logic o_h_sync_c,
  output logic o_v_sync_c,
  output logic o_sof_c
);

  localparam axis_timing_t H_TIM = '{
    active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)
  };
  localparam axis_timing_t V_TIM = '{
    active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)
  };

  localparam int unsigned H_TOTAL = axis_total(H_TIM);
  localparam int unsigned V_TOTAL = axis_total(V_TIM);
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;
  region_e       w_h_region;
  region_e       w_v_region;

  assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

  // Pixel counter wraps at end of line and advances the line counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  // Region decode of the current raster position.
  always_comb begin
    w_h_region = axis_region(32'(r_h_cnt), H_ACTIVE, H_FP, H_SYNC);
    w_v_region = axis_region(32'(r_v_cnt), V_ACTIVE, V_FP, V_SYNC);
    o_de_c     = (w_h_region == REG_ACTIVE) && (w_v_region == REG_ACTIVE);
    o_h_sync_c = (w_h_region == REG_SYNC);
    o_v_sync_c = (w_v_region == REG_SYNC);
    o_sof_c    = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

endmodule

// File: rtl/mtl_video_timing_gen.sv
// Clocked-video output: locks a ready/valid SOP-marked pixel stream to a programmable raster.
module mtl_video_timing_gen
  import mtl_video_pkg::*;
#(
  parameter int unsigned COLOR_W  = MTL_COLOR_W,
  parameter int unsigned H_ACTIVE = 32'(MTL_H_TIMING.active),
  parameter int unsigned H_FP     = 32'(MTL_H_TIMING.fp),
  parameter int unsigned H_SYNC   = 32'(MTL_H_TIMING.sync),
  parameter int unsigned H_BP     = 32'(MTL_H_TIMING.bp),
  parameter int unsigned V_ACTIVE = 32'(MTL_V_TIMING.active),
  parameter int unsigned V_FP     = 32'(MTL_V_TIMING.fp),
  parameter int unsigned V_SYNC   = 32'(MTL_V_TIMING.sync),
  parameter int unsigned V_BP     = 32'(MTL_V_TIMING.bp),
  parameter bit          SYNC_POL = 1'b0,
  parameter logic [3*COLOR_W-1:0] UNDER_COLOR = '0
) (
  input  logic                 vid_clk,
  input  logic                 reset,
  input  logic [3*COLOR_W-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_sop,
  output logic                 in_ready,
  input  logic                 clr_status,
  output logic [3*COLOR_W-1:0] vid_data,
  output logic                 vid_de,
  output logic                 vid_hs,
  output logic                 vid_vs,
  output logic                 frame_start,
  output logic                 locked,
  output logic                 underflow,
  output logic                 sop_err
);

  localparam int unsigned PW        = 3 * COLOR_W;
  localparam logic        SYNC_ACT  = SYNC_POL;
  localparam logic        SYNC_IDLE = !SYNC_POL;

  logic          w_de_c;
  logic          w_h_sync_c;
  logic          w_v_sync_c;
  logic          w_sof_c;
  logic          w_sop_ok_c;
  logic          w_ready_c;
  logic          w_set_uf_c;
  logic          w_set_se_c;
  logic [PW-1:0] w_pix_c;
  state_e        r_state;
  state_e        w_state_nxt;

  logic [PW-1:0] r_vid_data;
  logic          r_vid_de;
  logic          r_vid_hs;
  logic          r_vid_vs;
  logic          r_frame_start;
  logic          r_locked;
  logic          r_underflow;
  logic          r_sop_err;

  video_hv_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_hv_counter (
    .i_clk      (vid_clk),
    .i_rst      (reset),
    .o_de_c     (w_de_c),
    .o_h_sync_c (w_h_sync_c),
    .o_v_sync_c (w_v_sync_c),
    .o_sof_c    (w_sof_c)
  );

  // SOP must be present exactly at raster (0,0) and nowhere else.
  assign w_sop_ok_c = (in_sop == w_sof_c);

  // Lock state register.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      r_state <= SYNC_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock on an SOP pixel at (0,0); drop lock on underflow or misplaced/missing SOP.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SYNC_WAIT: begin
        if (w_sof_c && in_valid && in_sop) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_de_c && (!in_valid || !w_sop_ok_c)) begin
          w_state_nxt = SYNC_WAIT;
        end
      end
      default: w_state_nxt = SYNC_WAIT;
    endcase
  end

  // Handshake, pixel selection and error detection for the current raster position.
  always_comb begin
    w_ready_c  = 1'b0;
    w_pix_c    = '0;
    w_set_uf_c = 1'b0;
    w_set_se_c = 1'b0;
    case (r_state)
      SYNC_WAIT: begin
        // Drain non-SOP pixels; hold the SOP pixel until (0,0).
        w_ready_c = !in_sop || (w_sof_c && in_valid);
        if (w_sof_c && in_valid && in_sop) begin
          w_pix_c = in_data;
        end else if (w_de_c) begin
          w_pix_c = UNDER_COLOR;
        end
      end
      RUN: begin
        // A misplaced SOP pixel is left on the bus for the resync.
        w_ready_c = w_de_c && w_sop_ok_c;
        if (w_de_c) begin
          if (!in_valid) begin
            w_set_uf_c = 1'b1;
            w_pix_c    = UNDER_COLOR;
          end else if (!w_sop_ok_c) begin
            w_set_se_c = 1'b1;
            w_pix_c    = UNDER_COLOR;
          end else begin
            w_pix_c = in_data;
          end
        end
      end
      default: begin
        w_ready_c = 1'b0;
      end
    endcase
  end

  assign in_ready = w_ready_c;

  // Output registers: one clock behind the raster counters; sticky flags give set priority.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      r_vid_data    <= '0;
      r_vid_de      <= 1'b0;
      r_vid_hs      <= SYNC_IDLE;
      r_vid_vs      <= SYNC_IDLE;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
      r_underflow   <= 1'b0;
      r_sop_err     <= 1'b0;
    end else begin
      r_vid_data    <= w_pix_c;
      r_vid_de      <= w_de_c;
      r_vid_hs      <= w_h_sync_c ? SYNC_ACT : SYNC_IDLE;
      r_vid_vs      <= w_v_sync_c ? SYNC_ACT : SYNC_IDLE;
      r_frame_start <= w_sof_c;
      r_locked      <= (w_state_nxt == RUN);
      r_underflow   <= w_set_uf_c | (r_underflow & !clr_status);
      r_sop_err     <= w_set_se_c | (r_sop_err & !clr_status);
    end
  end

  assign vid_data    = r_vid_data;
  assign vid_de      = r_vid_de;
  assign vid_hs      = r_vid_hs;
  assign vid_vs      = r_vid_vs;
  assign frame_start = r_frame_start;
  assign locked      = r_locked;
  assign underflow   = r_underflow;
  assign sop_err     = r_sop_err;

endmodule

// File: tb/tb_mtl_video_timing_gen.sv
// Bench: small-raster generator checked cycle by cycle against a behavioural raster/lock model.
module tb_mtl_video_timing_gen;

  // Main instance: small raster, active-low syncs, distinctive fill colour.
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int NPIX = HA * VA;
  localparam logic [23:0] UC = 24'hA55A3C;

  // Second instance: different geometry, active-high syncs, free running.
  localparam int HA2 = 10, HFP2 = 1, HS2 = 2, HBP2 = 3;
  localparam int VA2 = 3, VFP2 = 1, VS2 = 1, VBP2 = 2;
  localparam int HT2 = HA2 + HFP2 + HS2 + HBP2;
  localparam int VT2 = VA2 + VFP2 + VS2 + VBP2;

  typedef enum int {M_IDLE, M_STREAM, M_DROP, M_EARLY, M_CLR, M_NOSOP, M_GAP, M_RAND} mode_e;

  typedef struct {
    mode_e mode;
    int    cycles;
    int    exp_locked;
    int    exp_uf;
    int    exp_se;
  } phase_t;

  logic        vid_clk = 1'b0;
  logic        reset;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_ready;
  logic        clr_status;
  logic [23:0] vid_data;
  logic        vid_de, vid_hs, vid_vs, frame_start, locked, underflow, sop_err;

  logic        d2_ready;
  logic [23:0] d2_data;
  logic        d2_de, d2_hs, d2_vs, d2_fs, d2_locked, d2_uf, d2_se;

  int          n_chk = 0;
  int          n_err = 0;
  int          t = 0;
  int          k = 0;
  int          n_cons = 0;
  bit          cnt_en = 1'b0;
  bit          fired = 1'b0;
  bit          m_locked = 1'b0;
  bit          m_uf = 1'b0;
  bit          m_se = 1'b0;
  logic [23:0] pix = '0;

  always #5 vid_clk = ~vid_clk;

  mtl_video_timing_gen #(
    .COLOR_W(8), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .UNDER_COLOR(UC)
  ) dut (
    .vid_clk(vid_clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_ready(in_ready), .clr_status(clr_status),
    .vid_data(vid_data), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .frame_start(frame_start), .locked(locked), .underflow(underflow), .sop_err(sop_err)
  );

  mtl_video_timing_gen #(
    .COLOR_W(8), .H_ACTIVE(HA2), .H_FP(HFP2), .H_SYNC(HS2), .H_BP(HBP2),
    .V_ACTIVE(VA2), .V_FP(VFP2), .V_SYNC(VS2), .V_BP(VBP2),
    .SYNC_POL(1'b1)
  ) dut2 (
    .vid_clk(vid_clk), .reset(reset), .in_data(24'h0), .in_valid(1'b0),
    .in_sop(1'b0), .in_ready(d2_ready), .clr_status(1'b0),
    .vid_data(d2_data), .vid_de(d2_de), .vid_hs(d2_hs), .vid_vs(d2_vs),
    .frame_start(d2_fs), .locked(d2_locked), .underflow(d2_uf), .sop_err(d2_se)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h expected %0h", nm, t, act, exp);
    end
  endfunction

  function automatic logic in_rng(input int x, input int lo, input int n);
    return (x >= lo) && (x < lo + n);
  endfunction

  // Every output of both instances at its reset value.
  task automatic check_reset_state();
    logic [31:0] act [11];
    logic [31:0] exp [11];
    string       nm  [11];
    nm  = '{"rst_vid_data", "rst_vid_de", "rst_vid_hs", "rst_vid_vs", "rst_frame_start",
            "rst_locked", "rst_underflow", "rst_sop_err", "rst_d2_hs", "rst_d2_vs", "rst_d2_de"};
    exp = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    act = '{32'(vid_data), 32'(vid_de), 32'(vid_hs), 32'(vid_vs), 32'(frame_start),
            32'(locked), 32'(underflow), 32'(sop_err), 32'(d2_hs), 32'(d2_vs), 32'(d2_de)};
    for (int i = 0; i < 11; i++) check(nm[i], act[i], exp[i]);
  endtask

  // One pixel clock: drive the source, predict, check in_ready, clock, check registered outputs.
  task automatic do_cycle(input mode_e mode, input int c);
    int h, v, h2, v2;
    logic iv, isop, iclr, sup, sof, de, rdy, nlk, suf, sse, euf, ese;
    logic [23:0] ed;
    h  = t % HT;  v  = (t / HT) % VT;
    h2 = t % HT2; v2 = (t / HT2) % VT2;
    iv = 1'b1; iclr = 1'b0; sup = 1'b0;
    case (mode)
      M_IDLE:   iv = 1'b0;
      M_STREAM: iv = 1'b1;
      M_DROP:   if (!fired && h == 5 && v == 2) begin iv = 1'b0; fired = 1'b1; end
      M_EARLY:  if (!fired && m_locked && h == 3 && v == 0) begin
                  k = 0; pix = 24'($urandom); iclr = 1'b1; fired = 1'b1;
                end
      M_CLR:    iclr = (c == 0);
      M_NOSOP:  if (!fired && h == 0 && v == 0) begin sup = 1'b1; fired = 1'b1; end
      M_GAP: begin
        iclr = (c == 0);
        if (!fired && h == 0 && v == 0) begin iv = 1'b0; fired = 1'b1; end
      end
      default: begin
        iv = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 63) == 0) begin k = 0; pix = 24'($urandom); end
        iclr = ($urandom_range(0, 31) == 0);
      end
    endcase
    isop = (k == 0) && !sup;
    in_valid = iv; in_sop = isop; in_data = pix; clr_status = iclr;
    #1;
    sof = (h == 0) && (v == 0);
    de  = (h < HA) && (v < VA);
    suf = 1'b0; sse = 1'b0; nlk = m_locked; ed = '0;
    if (!m_locked) begin
      rdy = !isop || (sof && iv);
      if (sof && iv && isop) begin nlk = 1'b1; ed = pix; end
      else if (de) ed = UC;
    end else begin
      rdy = de && (isop == sof);
      if (de) begin
        if (!iv) begin suf = 1'b1; nlk = 1'b0; ed = UC; end
        else if (isop != sof) begin sse = 1'b1; nlk = 1'b0; ed = UC; end
        else ed = pix;
      end
    end
    euf = suf | (m_uf & !iclr);
    ese = sse | (m_se & !iclr);
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("d2_in_ready", 32'(d2_ready), 32'd1);
    if (cnt_en && t >= 240 && t < 360 && in_valid && in_ready) n_cons++;
    if (iv && rdy) begin k = (k + 1) % NPIX; pix = 24'($urandom); end
    @(posedge vid_clk); #1;
    check("vid_data", 32'(vid_data), 32'(ed));
    check("vid_de", 32'(vid_de), 32'(de));
    check("vid_hs", 32'(vid_hs), 32'(!in_rng(h, HA + HFP, HS)));
    check("vid_vs", 32'(vid_vs), 32'(!in_rng(v, VA + VFP, VS)));
    check("frame_start", 32'(frame_start), 32'(sof));
    check("locked", 32'(locked), 32'(nlk));
    check("underflow", 32'(underflow), 32'(euf));
    check("sop_err", 32'(sop_err), 32'(ese));
    check("d2_de", 32'(d2_de), 32'((h2 < HA2) && (v2 < VA2)));
    check("d2_hs", 32'(d2_hs), 32'(in_rng(h2, HA2 + HFP2, HS2)));
    check("d2_vs", 32'(d2_vs), 32'(in_rng(v2, VA2 + VFP2, VS2)));
    check("d2_frame_start", 32'(d2_fs), 32'((h2 == 0) && (v2 == 0)));
    check("d2_vid_data", 32'(d2_data), 32'h0);
    check("d2_flags", {29'd0, d2_locked, d2_uf, d2_se}, 32'h0);
    m_locked = nlk; m_uf = euf; m_se = ese;
    t++;
  endtask

  task automatic run_phase(input phase_t p);
    fired = 1'b0;
    for (int c = 0; c < p.cycles; c++) do_cycle(p.mode, c);
    if (p.exp_locked >= 0) check("end_locked", 32'(locked), 32'(p.exp_locked));
    if (p.exp_uf >= 0)     check("end_underflow", 32'(underflow), 32'(p.exp_uf));
    if (p.exp_se >= 0)     check("end_sop_err", 32'(sop_err), 32'(p.exp_se));
  endtask

  initial begin
    phase_t ph [8];
    int     guard;
    ph[0] = '{M_IDLE,    130,  0,  0,  0};
    ph[1] = '{M_STREAM,  300,  1,  0,  0};
    ph[2] = '{M_DROP,    250,  1,  1,  0};
    ph[3] = '{M_EARLY,   250,  1,  0,  1};
    ph[4] = '{M_CLR,     130,  1,  0,  0};
    ph[5] = '{M_NOSOP,   250,  1,  0,  1};
    ph[6] = '{M_GAP,     250,  1,  1,  0};
    ph[7] = '{M_RAND,   1200, -1, -1, -1};

    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; clr_status = 1'b0;
    pix = 24'($urandom);
    @(posedge vid_clk); #1;
    check_reset_state();
    reset = 1'b0;

    for (int p = 0; p < 8; p++) begin
      cnt_en = (p == 1);
      run_phase(ph[p]);
      if (p == 1) check("pixels_per_frame", 32'(n_cons), 32'(NPIX));
    end
    cnt_en = 1'b0;

    // Mid-frame asynchronous reset on an active line, then relock from (0,0).
    fired = 1'b0;
    guard = 0;
    while (!((t % HT) == 4 && ((t / HT) % VT) == 2) && guard < HT * VT) begin
      do_cycle(M_STREAM, guard);
      guard++;
    end
    check("reach_line2", 32'(((t / HT) % VT) == 2), 32'd1);
    @(negedge vid_clk);
    reset = 1'b1;
    #1;
    check_reset_state();
    @(posedge vid_clk); #1;
    check_reset_state();
    reset = 1'b0;
    t = 0; k = 0; m_locked = 1'b0; m_uf = 1'b0; m_se = 1'b0;
    pix = 24'($urandom);
    run_phase('{M_STREAM, 250, 1, 0, 0});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
